avalon_pwm_slave: RTL and testbench

Avalon-MM slave (responder) peripheral: the target end of the simple-master bus. It decodes word-addressed read/write transfers into a register file and drives an 8-channel PWM output bank. All channels share one period counter and each has its own duty register. Period and duty values are double-buffered and take effect only at a period boundary, so outputs never glitch mid-period.

---
 rtl/avalon_pwm_slave_if.sv | 21 ++
 rtl/avalon_pwm_slave.sv | 137 +++++++++++++
 tb/tb_avalon_pwm_slave.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/avalon_pwm_slave_if.sv
// Avalon-MM bus bundle between a simple master and the PWM slave.
// Latency: none, wires only.
// Backpressure: the slave drives avs_waitrequest and the master holds its request until it falls.
interface avalon_pwm_slave_if;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/avalon_pwm_slave.sv
// Avalon-MM slave register file driving a bank of double-buffered PWM channels sharing one counter.
// Latency: each bus transfer takes 2 cycles (accept, ack); pwm_out lags the counter by 1 cycle.
// Backpressure: waitrequest is high only in the accept cycle of a request, low in the ack cycle.
module avalon_pwm_slave #(
  parameter int CNT_W  = 16,
  parameter int NUM_CH = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  avalon_pwm_slave_if.slave avs,
  output logic [NUM_CH-1:0] pwm_out
);
  // Captured write data must hold CTRL's two bits even for very narrow counters.
  localparam int DW = (CNT_W > 2) ? CNT_W : 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [DW-1:0]    wdat_q, wdat_d;
  logic             is_wr_q, is_wr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic [CNT_W-1:0] duty_sh_q  [NUM_CH];
  logic [CNT_W-1:0] duty_sh_d  [NUM_CH];
  logic [CNT_W-1:0] duty_act_q [NUM_CH];
  logic [CNT_W-1:0] duty_act_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [NUM_CH-1:0] raw;
  logic [31:0]      rd_mux;
  logic             req;
  logic             wrap;
  logic             load_act;

  assign req                 = avs.avs_read | avs.avs_write;
  assign avs.avs_waitrequest = (state_q == ST_IDLE) & req;
  assign avs.avs_readdata    = rdata_q;
  assign pwm_out             = pwm_q;

  // Read decode of the live request address; shadows are returned, not active copies.
  always_comb begin
    rd_mux = '0;
    if (avs.avs_address == 8'h00)      rd_mux = 32'(ctrl_q);
    else if (avs.avs_address == 8'h01) rd_mux = 32'(period_sh_q);
    else if (avs.avs_address == 8'h0A) rd_mux = 32'(cnt_q);
    else if (avs.avs_address == 8'h0B) rd_mux = 32'(pwm_q);
    for (int i = 0; i < NUM_CH; i++) begin
      if (avs.avs_address == 8'(i + 2)) rd_mux = 32'(duty_sh_q[i]);
    end
  end

  // Bus FSM: capture in IDLE, commit writes at the end of ACK.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    is_wr_d     = is_wr_q;
    rdata_d     = rdata_q;
    ctrl_d      = ctrl_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    if (state_q == ST_IDLE) begin
      if (req) begin
        addr_d  = avs.avs_address;
        wdat_d  = avs.avs_writedata[DW-1:0];
        is_wr_d = avs.avs_write;
        // A write wins over a simultaneous read and returns zero data.
        rdata_d = avs.avs_write ? 32'h0 : rd_mux;
        state_d = ST_ACK;
      end
    end else begin
      state_d = ST_IDLE;
      if (is_wr_q) begin
        if (addr_q == 8'h00) ctrl_d = wdat_q[1:0];
        if (addr_q == 8'h01) period_sh_d = wdat_q[CNT_W-1:0];
        for (int i = 0; i < NUM_CH; i++) begin
          if (addr_q == 8'(i + 2)) duty_sh_d[i] = wdat_q[CNT_W-1:0];
        end
      end
    end
  end

  // Counter, active-copy reload at wrap or enable rise, and registered polarity-adjusted outputs.
  always_comb begin
    wrap         = (cnt_q >= period_act_q);
    load_act     = (ctrl_q[0] & wrap) | (~ctrl_q[0] & ctrl_d[0]);
    period_act_d = load_act ? period_sh_q : period_act_q;
    duty_act_d   = duty_act_q;
    raw          = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load_act) duty_act_d[i] = duty_sh_q[i];
      raw[i] = ctrl_q[0] & (cnt_q < duty_act_q[i]);
    end
    // Counting only continues while enabled now and next cycle, so a disable zeroes it at once.
    cnt_d = (ctrl_q[0] & ctrl_d[0]) ? (wrap ? '0 : cnt_q + 1'b1) : '0;
    pwm_d = raw ^ {NUM_CH{ctrl_q[1]}};
  end

  // State registers, all cleared asynchronously so an in-flight write is dropped.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdat_q       <= '0;
      is_wr_q      <= 1'b0;
      rdata_q      <= '0;
      ctrl_q       <= '0;
      period_sh_q  <= '0;
      period_act_q <= '0;
      cnt_q        <= '0;
      pwm_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdat_q       <= wdat_d;
      is_wr_q      <= is_wr_d;
      rdata_q      <= rdata_d;
      ctrl_q       <= ctrl_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
    end
  end
endmodule

// File: tb/tb_avalon_pwm_slave.sv
// Self-checking bench for avalon_pwm_slave: register map vectors plus PWM timing sequences.
// Latency: checks the 2-cycle transfer and 1-cycle output lag explicitly.
// Backpressure: every transfer is expected to stall exactly one cycle.
module tb_avalon_pwm_slave;
  logic       clk_clk;
  logic       reset_reset_n;
  logic [7:0] pwm_out;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;

  avalon_pwm_slave_if bus ();

  avalon_pwm_slave #(.CNT_W(16), .NUM_CH(8)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .avs           (bus),
    .pwm_out       (pwm_out)
  );

  typedef struct {
    logic [7:0]  a;
    logic        r;
    logic        w;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  always @(posedge clk_clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after ACK with the request dropped.
  task automatic xfer(input logic [7:0] a, input logic r, input logic w, input logic [31:0] d,
                      output logic [31:0] q, output int waits, output int t0);
    t0 = cyc;
    bus.avs_address   = a;
    bus.avs_read      = r;
    bus.avs_write     = w;
    bus.avs_writedata = d;
    #1;
    waits = 0;
    while (bus.avs_waitrequest && waits < 8) begin
      waits++;
      @(posedge clk_clk);
      #2;
    end
    q = bus.avs_readdata;
    @(posedge clk_clk);
    #1;
    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
  endtask

  initial begin
    logic [31:0] q;
    int waits, t0, n, w, m, prev, duty, s;
    logic [7:0] exp8;

    vecs[0]  = '{8'h01, 1'b0, 1'b1, 32'h0000_1234, 32'h0};
    vecs[1]  = '{8'h01, 1'b1, 1'b0, 32'h0,         32'h0000_1234};
    vecs[2]  = '{8'h0C, 1'b1, 1'b0, 32'h0,         32'h0};
    vecs[3]  = '{8'h0A, 1'b0, 1'b1, 32'h0000_0055, 32'h0};
    vecs[4]  = '{8'h0A, 1'b1, 1'b0, 32'h0,         32'h0};
    vecs[5]  = '{8'h01, 1'b0, 1'b1, 32'hFFFF_0009, 32'h0};
    vecs[6]  = '{8'h01, 1'b1, 1'b0, 32'h0,         32'h0000_0009};
    vecs[7]  = '{8'h02, 1'b0, 1'b1, 32'h0000_0003, 32'h0};
    vecs[8]  = '{8'h03, 1'b0, 1'b1, 32'h0000_0000, 32'h0};
    vecs[9]  = '{8'h04, 1'b0, 1'b1, 32'h0000_0014, 32'h0};
    vecs[10] = '{8'h02, 1'b1, 1'b0, 32'h0,         32'h0000_0003};
    vecs[11] = '{8'h04, 1'b1, 1'b0, 32'h0,         32'h0000_0014};
    vecs[12] = '{8'h0B, 1'b0, 1'b1, 32'h0000_00FF, 32'h0};
    vecs[13] = '{8'h0B, 1'b1, 1'b0, 32'h0,         32'h0};
    vecs[14] = '{8'h09, 1'b0, 1'b1, 32'h1234_00AA, 32'h0};
    vecs[15] = '{8'h09, 1'b1, 1'b0, 32'h0,         32'h0000_00AA};
    vecs[16] = '{8'h09, 1'b0, 1'b1, 32'h0,         32'h0};
    vecs[17] = '{8'h00, 1'b1, 1'b0, 32'h0,         32'h0};

    bus.avs_address   = '0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    reset_reset_n     = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    #1;
    chk("reset_waitrequest", 32'(bus.avs_waitrequest), 32'h0);
    chk("reset_pwm", 32'(pwm_out), 32'h0);
    chk("reset_readdata", bus.avs_readdata, 32'h0);
    tick();

    // Register map vectors.
    for (int i = 0; i < 18; i++) begin
      xfer(vecs[i].a, vecs[i].r, vecs[i].w, vecs[i].d, q, waits, t0);
      chk($sformatf("vec%0d_waits", i), 32'(waits), 32'h1);
      if (vecs[i].r) chk($sformatf("vec%0d_rdata", i), q, vecs[i].exp);
    end

    // Enable with PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=20. Cycle n has count 0.
    xfer(8'h00, 1'b0, 1'b1, 32'h1, q, waits, t0);
    n = cyc;
    for (int k = 0; k < 6; k++) begin
      xfer(8'h0A, 1'b1, 1'b0, 32'h0, q, waits, t0);
      chk($sformatf("t2_count%0d", k), q, 32'((t0 - n) % 10));
    end
    tick();
    xfer(8'h0A, 1'b1, 1'b0, 32'h0, q, waits, t0);
    chk("t2_count_odd", q, 32'((t0 - n) % 10));
    for (int k = 0; k < 20; k++) begin
      #1;
      m = cyc;
      exp8 = 8'h04 | {7'h0, (((m - n - 1) % 10) < 3)};
      chk($sformatf("t2_pwm_c%0d", m - n), 32'(pwm_out), 32'(exp8));
      @(posedge clk_clk);
      #1;
    end

    // Change DUTY0 to 7 at count 2; old 3-cycle pulse lasts to the wrap.
    for (int k = 0; k < 12 && ((cyc - n) % 10) != 2; k++) tick();
    chk("t3_align", 32'((cyc - n) % 10), 32'h2);
    w = cyc;
    xfer(8'h02, 1'b0, 1'b1, 32'h7, q, waits, t0);
    for (int k = 0; k < 25; k++) begin
      #1;
      m = cyc;
      prev = m - 1;
      duty = (prev >= w + 8) ? 7 : 3;
      exp8 = 8'h04 | {7'h0, (((prev - n) % 10) < duty)};
      chk($sformatf("t3_pwm_c%0d", m - w), 32'(pwm_out), 32'(exp8));
      @(posedge clk_clk);
      #1;
    end

    // Inverted polarity with DUTY0=3 after an enable edge.
    xfer(8'h00, 1'b0, 1'b1, 32'h0, q, waits, t0);
    xfer(8'h02, 1'b0, 1'b1, 32'h3, q, waits, t0);
    xfer(8'h00, 1'b0, 1'b1, 32'h3, q, waits, t0);
    n = cyc;
    tick();
    for (int k = 0; k < 20; k++) begin
      #1;
      m = cyc;
      exp8 = 8'hFA | {7'h0, !(((m - n - 1) % 10) < 3)};
      chk($sformatf("t4_pwm_c%0d", m - n), 32'(pwm_out), 32'(exp8));
      @(posedge clk_clk);
      #1;
    end
    xfer(8'h00, 1'b0, 1'b1, 32'h2, q, waits, t0);
    tick();
    chk("t4_idle_pwm", 32'(pwm_out), 32'hFF);
    xfer(8'h0A, 1'b1, 1'b0, 32'h0, q, waits, t0);
    chk("t4_idle_count", q, 32'h0);
    xfer(8'h00, 1'b1, 1'b0, 32'h0, q, waits, t0);
    chk("t4_ctrl_rd", q, 32'h2);

    // Reset asserted during the ACK cycle of a DUTY0=5 write.
    bus.avs_address   = 8'h02;
    bus.avs_writedata = 32'h5;
    bus.avs_write     = 1'b1;
    @(posedge clk_clk);
    #2;
    reset_reset_n = 1'b0;
    #1;
    chk("t5_wait_req_held", 32'(bus.avs_waitrequest), 32'h1);
    bus.avs_write = 1'b0;
    #1;
    chk("t5_waitrequest", 32'(bus.avs_waitrequest), 32'h0);
    chk("t5_pwm", 32'(pwm_out), 32'h0);
    chk("t5_readdata", bus.avs_readdata, 32'h0);
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    tick();
    xfer(8'h02, 1'b1, 1'b0, 32'h0, q, waits, t0);
    chk("t5_duty0", q, 32'h0);
    xfer(8'h00, 1'b1, 1'b0, 32'h0, q, waits, t0);
    chk("t5_ctrl", q, 32'h0);

    // Simultaneous read+write, then a back-to-back read.
    tick();
    s = cyc;
    xfer(8'h02, 1'b1, 1'b1, 32'h4, q, waits, t0);
    chk("t6_rw_rdata", q, 32'h0);
    chk("t6_rw_waits", 32'(waits), 32'h1);
    xfer(8'h02, 1'b1, 1'b0, 32'h0, q, waits, t0);
    chk("t6_b2b_rdata", q, 32'h4);
    chk("t6_b2b_start", 32'(t0 - s), 32'h2);
    chk("t6_b2b_end", 32'(cyc - s), 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
